pc_fetch_sequencer: RTL and testbench
=====================================

Name: pc_fetch_sequencer

Overview:
- Owns the architectural PC register and sequences each instruction through fetch, wait and execute phases.
- Issues instruction-memory read requests over a valid/ready handshake and presents the fetched instruction to the core.
- When the core signals completion, selects the next PC: sequential PC+4, or branch target PC+SignExtImm64 when Uncondbranch, or Branch with ALUZero, is asserted.
- Sits between instruction memory and the single-cycle datapath; it replaces the free-running PC register.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- CLK input 1: single clock; all state updates on the rising edge.
- Reset input 1: synchronous, active-high reset.
- IMemReqValid output 1: fetch request valid.
- IMemReqReady input 1: memory accepts the request.
- IMemAddr output 64: fetch address; always equals CurrentPC.
- IMemRespValid input 1: fetch data valid.
- IMemRespData input 32: fetched instruction word.
- Instruction output 32: latched instruction presented to the core.
- InstrValid output 1: high while the core may execute Instruction.
- ExecDone input 1: core has finished Instruction; branch inputs are valid this cycle.
- Branch input 1: conditional branch.
- Uncondbranch input 1: unconditional branch (B).
- ALUZero input 1: ALU zero flag.
- SignExtImm64 input 64: byte offset, already shifted.
- Halt input 1: stop after the current instruction.
- CurrentPC output 64: address of the current instruction.
- Retired output CNT_W: count of completed instructions.
- Halted output 1: sequencer is stopped.
- Fault output 1: misaligned target; present only with MISALIGN_TRAP_EN, otherwise tied 0.

Behaviour:
- States: REQ, WAIT, EXEC, HALTED, TRAP (TRAP exists only with the macro).
- Reset, when Reset=1 at a clock edge:
  - state=REQ, CurrentPC=RESET_PC, Instruction=0, Retired=0, Halted=0, Fault=0.
  - Reset overrides every other input and abandons any outstanding request.
  - Instruction memory shares the same Reset.
- Combinational outputs: IMemReqValid=1 only in REQ; InstrValid=1 only in EXEC.
- REQ:
  - Hold IMemReqValid and IMemAddr stable until IMemReqReady=1.
  - On acceptance go to WAIT.
  - IMemRespValid is ignored in REQ.
- WAIT:
  - On IMemRespValid=1, latch IMemRespData into Instruction and go to EXEC.
  - No timeout; the sequencer waits indefinitely.
- EXEC:
  - Instruction and CurrentPC are held constant.
  - On ExecDone=1, compute Taken = Uncondbranch | (Branch & ALUZero).
  - NextPC = Taken ? CurrentPC+SignExtImm64 : CurrentPC+4; both additions are modulo 2^64 and wrap silently.
  - At the same edge: CurrentPC<=NextPC and Retired<=Retired+1 (wraps at 2^CNT_W).
  - Next state is HALTED if Halt=1 that cycle, else REQ.
  - Halt without ExecDone has no effect.
- HALTED: Halted=1, no requests issued, all registers frozen; only Reset exits.
- Minimum throughput is 3 cycles per instruction (REQ accepted, response next cycle, ExecDone on the first EXEC cycle).
- Branch, Uncondbranch, ALUZero and SignExtImm64 are sampled only on the ExecDone cycle; they are don't-care otherwise.
- When both Uncondbranch and Branch are set, the branch is taken regardless of ALUZero.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - On ExecDone with NextPC[1:0]!=0, CurrentPC is not updated and Retired still increments.
  - State goes to TRAP with Fault=1 and Halted=1; Halt is irrelevant.
  - TRAP is sticky until Reset.
- Undefined:
  - No check is made; a misaligned NextPC is loaded and fetched as is.
  - Fault is tied 0.

Test Plan:
- Reset, RESET_PC=0x1000, ready=1, one-cycle response, ExecDone immediate, no branches -> IMemAddr sequence 0x1000, 0x1004, 0x1008; 3 cycles per instruction; Retired increments by 1 per instruction.
- Hold IMemReqReady=0 for 5 cycles in REQ -> IMemReqValid=1 and IMemAddr stable throughout; no state change; a spurious IMemRespValid in REQ is ignored.
- PC=0x2000, Branch=1, ALUZero=1, SignExtImm64=-16 -> next fetch at 0x1FF0. Repeat with ALUZero=0 -> 0x2004. Uncondbranch=1, imm=0x40 -> 0x2040.
- PC=64'hFFFF_FFFF_FFFF_FFFC, sequential -> PC wraps to 0. Retired preset near max -> wraps to 0.
- Halt=1 with ExecDone -> Halted=1, PC updated once, no further requests. Reset asserted mid-WAIT -> state REQ, PC=RESET_PC, Retired=0 on the next cycle.
- With MISALIGN_TRAP_EN, target 0x2002 -> Fault=1, Halted=1, CurrentPC unchanged, state held until Reset. Without the macro -> IMemAddr=0x2002 and Fault=0.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// PC owner and fetch/execute sequencer: REQ -> WAIT -> EXEC per instruction, stopping in HALTED.
// Define MISALIGN_TRAP_EN to trap (TRAP state, Fault=1) on a misaligned next PC.
module pc_fetch_sequencer #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             CLK,
   input  logic             Reset,
   output logic             IMemReqValid,
   input  logic             IMemReqReady,
   output logic [63:0]      IMemAddr,
   input  logic             IMemRespValid,
   input  logic [31:0]      IMemRespData,
   output logic [31:0]      Instruction,
   output logic             InstrValid,
   input  logic             ExecDone,
   input  logic             Branch,
   input  logic             Uncondbranch,
   input  logic             ALUZero,
   input  logic [63:0]      SignExtImm64,
   input  logic             Halt,
   output logic [63:0]      CurrentPC,
   output logic [CNT_W-1:0] Retired,
   output logic             Halted,
   output logic             Fault
);

`ifdef MISALIGN_TRAP_EN
   typedef enum logic [2:0] {StReq, StWait, StExec, StHalted, StTrap} state_e;
`else
   typedef enum logic [2:0] {StReq, StWait, StExec, StHalted} state_e;
`endif

   state_e           r_state;
   logic [63:0]      r_pc;
   logic [31:0]      r_instr;
   logic [CNT_W-1:0] r_retired;

   state_e           w_state_nxt;
   logic [63:0]      w_pc_nxt;
   logic [31:0]      w_instr_nxt;
   logic [CNT_W-1:0] w_retired_nxt;
   logic             w_taken;
   logic [63:0]      w_next_pc;

   // Branch inputs only matter on the ExecDone cycle; the adders wrap modulo 2^64.
   assign w_taken   = Uncondbranch | (Branch & ALUZero);
   assign w_next_pc = w_taken ? (r_pc + SignExtImm64) : (r_pc + 64'd4);

   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_state   <= StReq;
         r_pc      <= RESET_PC;
         r_instr   <= 32'h0;
         r_retired <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_pc      <= w_pc_nxt;
         r_instr   <= w_instr_nxt;
         r_retired <= w_retired_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_pc_nxt      = r_pc;
      w_instr_nxt   = r_instr;
      w_retired_nxt = r_retired;
      unique case (r_state)
         StReq: begin
            if (IMemReqReady) begin
               w_state_nxt = StWait;
            end
         end
         StWait: begin
            if (IMemRespValid) begin
               w_instr_nxt = IMemRespData;
               w_state_nxt = StExec;
            end
         end
         StExec: begin
            if (ExecDone) begin
               w_retired_nxt = r_retired + CNT_W'(1);
`ifdef MISALIGN_TRAP_EN
               // A misaligned target still retires the instruction but leaves the PC alone.
               if (w_next_pc[1:0] != 2'b00) begin
                  w_state_nxt = StTrap;
               end else begin
                  w_pc_nxt    = w_next_pc;
                  w_state_nxt = Halt ? StHalted : StReq;
               end
`else
               w_pc_nxt    = w_next_pc;
               w_state_nxt = Halt ? StHalted : StReq;
`endif
            end
         end
         default: begin
            w_state_nxt = r_state;
         end
      endcase
   end

   assign IMemReqValid = (r_state == StReq);
   assign IMemAddr     = r_pc;
   assign InstrValid   = (r_state == StExec);
   assign Instruction  = r_instr;
   assign CurrentPC    = r_pc;
   assign Retired      = r_retired;

`ifdef MISALIGN_TRAP_EN
   assign Halted = (r_state == StHalted) || (r_state == StTrap);
   assign Fault  = (r_state == StTrap);
`else
   assign Halted = (r_state == StHalted);
   assign Fault  = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Randomized bench for pc_fetch_sequencer: the bench plays instruction memory and the core,
// and predicts PC / retire count / halt state from the architectural rules.
module tb_pc_fetch_sequencer;

   localparam logic [63:0] RESET_PC = 64'h1000;
   localparam int unsigned CNT_W    = 6;

   logic             CLK = 1'b0;
   logic             Reset;
   logic             IMemReqValid;
   logic             IMemReqReady;
   logic [63:0]      IMemAddr;
   logic             IMemRespValid;
   logic [31:0]      IMemRespData;
   logic [31:0]      Instruction;
   logic             InstrValid;
   logic             ExecDone;
   logic             Branch;
   logic             Uncondbranch;
   logic             ALUZero;
   logic [63:0]      SignExtImm64;
   logic             Halt;
   logic [63:0]      CurrentPC;
   logic [CNT_W-1:0] Retired;
   logic             Halted;
   logic             Fault;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   // Architectural model state.
   logic [63:0] m_pc;
   int unsigned m_ret;
   bit          m_halt;
   bit          m_fault;

   pc_fetch_sequencer #(
      .RESET_PC (RESET_PC),
      .CNT_W    (CNT_W)
   ) dut (
      .CLK           (CLK),
      .Reset         (Reset),
      .IMemReqValid  (IMemReqValid),
      .IMemReqReady  (IMemReqReady),
      .IMemAddr      (IMemAddr),
      .IMemRespValid (IMemRespValid),
      .IMemRespData  (IMemRespData),
      .Instruction   (Instruction),
      .InstrValid    (InstrValid),
      .ExecDone      (ExecDone),
      .Branch        (Branch),
      .Uncondbranch  (Uncondbranch),
      .ALUZero       (ALUZero),
      .SignExtImm64  (SignExtImm64),
      .Halt          (Halt),
      .CurrentPC     (CurrentPC),
      .Retired       (Retired),
      .Halted        (Halted),
      .Fault         (Fault)
   );

   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_arch(input string tag);
      check_eq({tag, "_pc"}, CurrentPC, m_pc);
      check_eq({tag, "_ret"}, 64'(Retired), 64'(m_ret));
      check_eq({tag, "_halted"}, 64'(Halted), 64'(m_halt | m_fault));
      check_eq({tag, "_fault"}, 64'(Fault), 64'(m_fault));
   endtask

   task automatic idle_inputs();
      IMemReqReady  = 1'b0;
      IMemRespValid = 1'b0;
      IMemRespData  = 32'h0;
      ExecDone      = 1'b0;
      Branch        = 1'b0;
      Uncondbranch  = 1'b0;
      ALUZero       = 1'b0;
      SignExtImm64  = 64'h0;
      Halt          = 1'b0;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      idle_inputs();
      @(negedge CLK);
      @(negedge CLK);
      Reset   = 1'b0;
      m_pc    = RESET_PC;
      m_ret   = 0;
      m_halt  = 1'b0;
      m_fault = 1'b0;
      check_arch("rst");
      check_eq("rst_instr", 64'(Instruction), 64'h0);
      check_eq("rst_reqv", 64'(IMemReqValid), 64'h1);
      check_eq("rst_iv", 64'(InstrValid), 64'h0);
   endtask

   // One instruction, entered and left on a negedge with the DUT in REQ (or stopped on exit).
   task automatic run_instr(input logic br, input logic ub, input logic az, input logic [63:0] imm,
                            input logic hlt, input int req_stall, input int resp_dly,
                            input int exec_dly);
      logic [31:0] data;
      logic [63:0] nxt;
      check_eq("req_valid", 64'(IMemReqValid), 64'h1);
      check_eq("req_addr", IMemAddr, m_pc);
      check_eq("req_iv", 64'(InstrValid), 64'h0);
      for (int i = 0; i < req_stall; i++) begin
         IMemReqReady  = 1'b0;
         IMemRespValid = 1'($urandom);
         IMemRespData  = $urandom;
         @(negedge CLK);
         check_eq("stall_valid", 64'(IMemReqValid), 64'h1);
         check_eq("stall_addr", IMemAddr, m_pc);
      end
      IMemReqReady  = 1'b1;
      IMemRespValid = 1'($urandom);
      IMemRespData  = $urandom;
      @(negedge CLK);
      IMemReqReady  = 1'($urandom);
      IMemRespValid = 1'b0;
      check_eq("wait_reqv", 64'(IMemReqValid), 64'h0);
      check_eq("wait_iv", 64'(InstrValid), 64'h0);
      for (int i = 0; i < resp_dly; i++) begin
         @(negedge CLK);
         check_eq("wait_hold_iv", 64'(InstrValid), 64'h0);
      end
      data          = $urandom;
      IMemRespValid = 1'b1;
      IMemRespData  = data;
      @(negedge CLK);
      IMemRespValid = 1'b0;
      IMemRespData  = $urandom;
      IMemReqReady  = 1'b0;
      check_eq("exec_iv", 64'(InstrValid), 64'h1);
      check_eq("exec_instr", 64'(Instruction), 64'(data));
      for (int i = 0; i < exec_dly; i++) begin
         ExecDone     = 1'b0;
         Halt         = 1'($urandom);
         Branch       = 1'($urandom);
         Uncondbranch = 1'($urandom);
         ALUZero      = 1'($urandom);
         SignExtImm64 = {$urandom, $urandom};
         @(negedge CLK);
         check_eq("exec_hold_instr", 64'(Instruction), 64'(data));
         check_eq("exec_hold_pc", CurrentPC, m_pc);
         check_eq("exec_hold_iv", 64'(InstrValid), 64'h1);
      end
      ExecDone     = 1'b1;
      Branch       = br;
      Uncondbranch = ub;
      ALUZero      = az;
      SignExtImm64 = imm;
      Halt         = hlt;
      @(negedge CLK);
      idle_inputs();
      nxt   = (ub || (br && az)) ? m_pc + imm : m_pc + 64'd4;
      m_ret = (m_ret + 1) % (1 << CNT_W);
`ifdef MISALIGN_TRAP_EN
      if (nxt[1:0] != 2'b00) m_fault = 1'b1;
      else begin
         m_pc   = nxt;
         m_halt = hlt;
      end
`else
      m_pc   = nxt;
      m_halt = hlt;
`endif
      check_arch("done");
      check_eq("done_iv", 64'(InstrValid), 64'h0);
      check_eq("done_reqv", 64'(IMemReqValid), 64'(!(m_halt || m_fault)));
   endtask

   task automatic jump_to(input logic [63:0] target);
      run_instr(1'b0, 1'b1, 1'b0, target - m_pc, 1'b0, 0, 0, 0);
   endtask

   task automatic seq_instr();
      run_instr(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 0, 0, 0);
   endtask

   task automatic hold_stopped(input string tag, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         IMemReqReady  = 1'b1;
         IMemRespValid = 1'($urandom);
         ExecDone      = 1'($urandom);
         Uncondbranch  = 1'($urandom);
         SignExtImm64  = {$urandom, $urandom};
         @(negedge CLK);
         check_arch(tag);
         check_eq({tag, "_reqv"}, 64'(IMemReqValid), 64'h0);
      end
      idle_inputs();
   endtask

   initial begin
      Reset = 1'b1;
      idle_inputs();
      do_reset();

      // Straight-line fetch, minimum 3-cycle pacing.
      seq_instr();
      check_eq("seq_1004", IMemAddr, 64'h1004);
      seq_instr();
      check_eq("seq_1008", IMemAddr, 64'h1008);
      seq_instr();
      check_eq("seq_ret3", 64'(Retired), 64'd3);

      // Backpressure with spurious responses while in REQ.
      run_instr(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 5, 2, 1);

      jump_to(64'h2000);
      run_instr(1'b1, 1'b0, 1'b1, -64'sd16, 1'b0, 0, 0, 0);
      check_eq("br_taken", IMemAddr, 64'h1FF0);
      jump_to(64'h2000);
      run_instr(1'b1, 1'b0, 1'b0, -64'sd16, 1'b0, 0, 0, 0);
      check_eq("br_not_taken", IMemAddr, 64'h2004);
      jump_to(64'h2000);
      run_instr(1'b0, 1'b1, 1'b0, 64'h40, 1'b0, 0, 0, 0);
      check_eq("uncond", IMemAddr, 64'h2040);
      run_instr(1'b1, 1'b1, 1'b0, 64'h8, 1'b0, 0, 0, 0);
      check_eq("both_taken", IMemAddr, 64'h2048);

      jump_to(64'hFFFF_FFFF_FFFF_FFFC);
      seq_instr();
      check_eq("pc_wrap", IMemAddr, 64'h0);

      // Randomized traffic; long enough to wrap the retire counter.
      for (int n = 0; n < 90; n++) begin
         logic [63:0] imm;
         imm = (($urandom % 4) == 0) ? {$urandom, $urandom} : 64'($signed(12'($urandom)));
         imm[1:0] = 2'b00;
         run_instr(1'($urandom), 1'(($urandom % 4) == 0), 1'($urandom), imm, 1'b0,
                   int'($urandom % 3), int'($urandom % 3), int'($urandom % 3));
      end

      // Reset while waiting for a response, with the response arriving on the reset edge.
      IMemReqReady = 1'b1;
      @(negedge CLK);
      IMemReqReady  = 1'b0;
      Reset         = 1'b1;
      IMemRespValid = 1'b1;
      IMemRespData  = 32'hDEAD_BEEF;
      @(negedge CLK);
      Reset         = 1'b0;
      IMemRespValid = 1'b0;
      m_pc          = RESET_PC;
      m_ret         = 0;
      check_arch("mid_rst");
      check_eq("mid_rst_reqv", 64'(IMemReqValid), 64'h1);
      check_eq("mid_rst_instr", 64'(Instruction), 64'h0);

      // Misaligned target.
      jump_to(64'h2000);
      run_instr(1'b0, 1'b1, 1'b0, 64'h2, 1'b0, 0, 0, 0);
`ifdef MISALIGN_TRAP_EN
      check_eq("trap_pc", CurrentPC, 64'h2000);
      hold_stopped("trap_hold", 4);
      do_reset();
`else
      check_eq("misalign_addr", IMemAddr, 64'h2002);
      seq_instr();
      jump_to(64'h3000);
`endif

      // Halt: only honoured together with ExecDone.
      run_instr(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 0, 1, 3);
      hold_stopped("halt_hold", 5);
      do_reset();
      seq_instr();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
